// File: rtl/reg_bank_ctx.sv
// Register bank with two combinational read ports, one write port and a
// context save/restore streaming engine. Optional macro: REG_BANK_BYPASS_EN.
module reg_bank_ctx #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd1_addr,
    output logic [DW-1:0] rd1_data,
    input  logic [AW-1:0] rd2_addr,
    output logic [DW-1:0] rd2_data,
    input  logic          sv_start,
    output logic          sv_valid,
    input  logic          sv_ready,
    output logic [AW-1:0] sv_idx,
    output logic [DW-1:0] sv_data,
    input  logic          rs_start,
    input  logic          rs_valid,
    output logic          rs_ready,
    input  logic [DW-1:0] rs_data,
    output logic          busy,
    output logic          ctx_done
);

    localparam int unsigned NREG = 2 ** AW;
    localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

    typedef enum logic [1:0] {StIdle, StSave, StRestore} state_e;

    state_e        r_state, w_state_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic          r_done, w_done_nxt;
    logic [DW-1:0] r_regs [NREG];

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Save wins when both requests arrive together.
                if (sv_start) begin
                    w_state_nxt = StSave;
                    w_cnt_nxt   = '0;
                end else if (rs_start) begin
                    w_state_nxt = StRestore;
                    w_cnt_nxt   = '0;
                end
            end
            StSave: begin
                if (sv_ready) begin
                    if (r_cnt == LastIdx) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            StRestore: begin
                if (rs_valid) begin
                    if (r_cnt == LastIdx) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Architectural writes only in IDLE; restore beats own the port otherwise.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_addr;
        w_wdata = wr_data;
        if (r_state == StIdle) begin
            w_we = wr_en;
        end else if (r_state == StRestore) begin
            w_we    = rs_valid;
            w_waddr = r_cnt;
            w_wdata = rs_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

    assign sv_valid = (r_state == StSave);
    assign rs_ready = (r_state == StRestore);
    assign busy     = (r_state != StIdle);
    assign ctx_done = r_done;
    assign sv_idx   = r_cnt;
    assign sv_data  = r_regs[r_cnt];

`ifdef REG_BANK_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok = rst_n && wr_en && (r_state == StIdle);
    assign rd1_data = (w_byp_ok && (wr_addr == rd1_addr)) ? wr_data : r_regs[rd1_addr];
    assign rd2_data = (w_byp_ok && (wr_addr == rd2_addr)) ? wr_data : r_regs[rd2_addr];
`else
    assign rd1_data = r_regs[rd1_addr];
    assign rd2_data = r_regs[rd2_addr];
`endif

endmodule

// File: tb/tb_reg_bank_ctx.sv
// Scoreboard bench for reg_bank_ctx: expected save beats are queued at request
// time and popped by an independent monitor on each sv handshake.
module tb_reg_bank_ctx;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NREG = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd1_addr, rd2_addr;
    logic [DW-1:0] rd1_data, rd2_data;
    logic          sv_start, sv_valid, sv_ready;
    logic [AW-1:0] sv_idx;
    logic [DW-1:0] sv_data;
    logic          rs_start, rs_valid, rs_ready;
    logic [DW-1:0] rs_data;
    logic          busy, ctx_done;

    reg_bank_ctx #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd1_addr (rd1_addr),
        .rd1_data (rd1_data),
        .rd2_addr (rd2_addr),
        .rd2_data (rd2_data),
        .sv_start (sv_start),
        .sv_valid (sv_valid),
        .sv_ready (sv_ready),
        .sv_idx   (sv_idx),
        .sv_data  (sv_data),
        .rs_start (rs_start),
        .rs_valid (rs_valid),
        .rs_ready (rs_ready),
        .rs_data  (rs_data),
        .busy     (busy),
        .ctx_done (ctx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    logic [DW-1:0] model [NREG];
    int exp_idx_q [$];
    logic [DW-1:0] exp_data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected save beats, checks stall stability, counts done pulses.
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_idx;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        if (ctx_done) n_done++;
        if (sv_valid && prev_stall) begin
            check("sv_idx_stall", 32'(sv_idx), 32'(prev_idx));
            check("sv_data_stall", 32'(sv_data), 32'(prev_data));
        end
        if (sv_valid && sv_ready) begin
            if (exp_idx_q.size() == 0) begin
                check("sv_extra_beat", 32'(sv_idx), 32'hFFFF_FFFF);
            end else begin
                check("sv_idx", 32'(sv_idx), 32'(exp_idx_q.pop_front()));
                check("sv_data", 32'(sv_data), 32'(exp_data_q.pop_front()));
            end
        end
        prev_stall = sv_valid && !sv_ready;
        prev_idx   = sv_idx;
        prev_data  = sv_data;
    end

    task automatic check_all(input string name);
        for (int i = 0; i < NREG; i++) begin
            rd1_addr = AW'(i);
            rd2_addr = AW'(NREG - 1 - i);
            #1;
            check({name, "_rd1"}, 32'(rd1_data), 32'(model[i]));
            check({name, "_rd2"}, 32'(rd2_data), 32'(model[NREG - 1 - i]));
        end
    endtask

    task automatic idle_write(input int addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[addr] = data;
    endtask

    // mode 0: always ready, 1: ready 1,0,0 pattern, 2: random ready
    task automatic do_save(input int mode, input bit both_start, input bit noise);
        int cycles = 0;
        int done0;
        for (int i = 0; i < NREG; i++) begin
            exp_idx_q.push_back(i);
            exp_data_q.push_back(model[i]);
        end
        done0 = n_done;
        @(posedge clk); #1;
        sv_start = 1'b1; rs_start = both_start;
        @(posedge clk); #1;
        sv_start = 1'b0; rs_start = 1'b0;
        check("sv_latency", 32'(sv_valid), 32'd1);
        check("save_rs_ready", 32'(rs_ready), 32'd0);
        check("save_busy", 32'(busy), 32'd1);
        while (busy && cycles < 200) begin
            case (mode)
                0:       sv_ready = 1'b1;
                1:       sv_ready = (cycles % 3 == 0);
                default: sv_ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD;
                rs_start = 1'($urandom_range(0, 1));
                sv_start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cycles++;
        end
        wr_en = 1'b0; rs_start = 1'b0; sv_start = 1'b0; sv_ready = 1'b0;
        check("save_timeout", 32'(busy), 32'd0);
        if (mode == 0) check("save_cycles", 32'(cycles), 32'd8);
        check("done_at_end", 32'(ctx_done), 32'd1);
        @(negedge clk); @(negedge clk); #1;
        check("save_left", 32'(exp_idx_q.size()), 32'd0);
        check("save_done_cnt", 32'(n_done - done0), 32'd1);
        exp_idx_q.delete();
        exp_data_q.delete();
    endtask

    task automatic do_restore(input int nbeats, input logic [DW-1:0] base, input bit full);
        int cycles = 0;
        int beat = 0;
        int done0;
        bit acc;
        done0 = n_done;
        @(posedge clk); #1;
        rs_start = 1'b1;
        @(posedge clk); #1;
        rs_start = 1'b0;
        check("rs_latency", 32'(rs_ready), 32'd1);
        check("restore_sv_valid", 32'(sv_valid), 32'd0);
        while (beat < nbeats && cycles < 200) begin
            rs_valid = 1'($urandom_range(0, 1));
            rs_data  = base + DW'(beat);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom);
            wr_data  = DW'($urandom);
            sv_start = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = rs_valid && rs_ready;
            @(posedge clk); #1;
            if (acc) begin
                model[beat] = base + DW'(beat);
                beat++;
            end
            cycles++;
        end
        rs_valid = 1'b0; wr_en = 1'b0; sv_start = 1'b0;
        check("restore_beats", 32'(beat), 32'(nbeats));
        if (full) begin
            check("restore_busy", 32'(busy), 32'd0);
            check("restore_done", 32'(ctx_done), 32'd1);
            @(negedge clk); @(negedge clk); #1;
            check("restore_done_cnt", 32'(n_done - done0), 32'd1);
        end
    endtask

    initial begin
        int done0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd1_addr = '0; rd2_addr = '0;
        sv_start = 1'b0; sv_ready = 1'b0;
        rs_start = 1'b0; rs_valid = 1'b0; rs_data = '0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sv_valid", 32'(sv_valid), 32'd0);
        check("rst_sv_idx", 32'(sv_idx), 32'd0);
        check("rst_rs_ready", 32'(rs_ready), 32'd0);
        check("rst_done", 32'(ctx_done), 32'd0);
        check("rst_rd1", 32'(rd1_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NREG; i++) idle_write(i, 16'h1000 + DW'(i));
        rd1_addr = 3'd3; rd2_addr = 3'd7; #1;
        check("rd1_a3", 32'(rd1_data), 32'h1003);
        check("rd2_a7", 32'(rd2_data), 32'h1007);
        check_all("init");

        do_save(0, 1'b0, 1'b0);
        do_save(1, 1'b0, 1'b1);
        check_all("after_stall_save");
        do_save(2, 1'b1, 1'b0);

        do_restore(NREG, 16'hA000, 1'b1);
        check_all("restore_a");

        do_restore(3, 16'hB000, 1'b0);
        done0 = n_done;
        rst_n = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rs_ready", 32'(rs_ready), 32'd0);
        check_all("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(n_done - done0), 32'd0);

        do_restore(NREG, 16'hC000, 1'b1);
        check_all("restore_c");
        do_save(2, 1'b0, 1'b0);

        // same-cycle visibility of a write
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5A5A; rd1_addr = 3'd5; #1;
`ifdef REG_BANK_BYPASS_EN
        check("bypass_same", 32'(rd1_data), 32'h5A5A);
`else
        check("nobypass_same", 32'(rd1_data), 32'(model[5]));
`endif
        @(posedge clk); #1;
        wr_en = 1'b0; model[5] = 16'h5A5A;
        check("write_next", 32'(rd1_data), 32'h5A5A);

        for (int k = 0; k < 40; k++) begin
            int a;
            logic [DW-1:0] d;
            logic we;
            a = $urandom_range(0, NREG - 1);
            d = DW'($urandom);
            we = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            wr_en = we; wr_addr = AW'(a); wr_data = d;
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (we) model[a] = d;
            rd1_addr = AW'(a); rd2_addr = AW'($urandom); #1;
            check("rand_rd1", 32'(rd1_data), 32'(model[a]));
            check("rand_rd2", 32'(rd2_data), 32'(model[rd2_addr]));
        end
        check_all("final");
        do_save(2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bank_ctx.md
REG_BANK_CTX -- requirements
Module: reg_bank_ctx

Interface
REQ-001 SHALL have parameter DW, default 16, data width of each register (DW >= 1).
REQ-002 SHALL have parameter AW, default 3, register index width; register count NREG = 2**AW.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports wr_en  input  1, wr_addr  input  AW, wr_data  input  DW  for the architectural write port.
REQ-006 SHALL have ports rd1_addr  input  AW, rd1_data  output  DW, rd2_addr  input  AW, rd2_data  output  DW  for the two combinational read ports.
REQ-007 SHALL have ports sv_start  input  1  (save request pulse), sv_valid  output  1, sv_ready  input  1, sv_idx  output  AW, sv_data  output  DW  for the context-save stream.
REQ-008 SHALL have ports rs_start  input  1  (restore request pulse), rs_valid  input  1, rs_ready  output  1, rs_data  input  DW  for the context-restore stream.
REQ-009 SHALL have ports busy  output  1  (FSM not IDLE) and ctx_done  output  1  (one-cycle completion pulse).

Function
REQ-010 SHALL implement FSM states IDLE, SAVE, RESTORE, plus a beat counter cnt of AW bits.
REQ-011 In IDLE, sv_start=1 SHALL move to SAVE with cnt=0; rs_start=1 (sv_start=0) SHALL move to RESTORE with cnt=0; both asserted SHALL select SAVE.
REQ-012 sv_start/rs_start asserted outside IDLE SHALL be ignored.
REQ-013 In SAVE, sv_valid=1, sv_idx=cnt, sv_data=r[cnt]; both SHALL hold stable while sv_ready=0.
REQ-014 In SAVE, each cycle with sv_valid&&sv_ready SHALL increment cnt; the beat at cnt=NREG-1 SHALL return to IDLE (no cnt wrap beat).
REQ-015 In RESTORE, rs_ready=1; each cycle with rs_valid&&rs_ready SHALL write rs_data to r[cnt] and increment cnt; the beat at cnt=NREG-1 SHALL return to IDLE.
REQ-016 sv_valid SHALL be 0 outside SAVE; rs_ready SHALL be 0 outside RESTORE.
REQ-017 First sv_valid/rs_ready SHALL assert the cycle after the accepted start (latency 1).
REQ-018 ctx_done SHALL pulse high for exactly one cycle, the cycle after the final beat of SAVE or RESTORE.
REQ-019 busy SHALL equal (state != IDLE).
REQ-020 In IDLE, wr_en=1 SHALL write wr_data to r[wr_addr] at the clock edge.
REQ-021 While busy=1, wr_en SHALL be ignored (no register changes except restore beats).
REQ-022 rdN_data SHALL equal r[rdN_addr] combinationally in all states, including during SAVE/RESTORE.
REQ-023 NREG registers SHALL be independent; a write SHALL never alter any other index.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear all registers to 0, state to IDLE, cnt to 0.
REQ-025 During reset: sv_valid=0, sv_idx=0, rs_ready=0, busy=0, ctx_done=0; rdN_data=0.
REQ-026 Reset asserted mid-SAVE or mid-RESTORE SHALL abort the transfer with no ctx_done pulse.

Configuration
REQ-027 Macro REG_BANK_BYPASS_EN defined: when wr_en=1 is accepted (IDLE) and wr_addr==rdN_addr, rdN_data SHALL return wr_data in the same cycle.
REQ-028 REG_BANK_BYPASS_EN undefined: rdN_data SHALL return the stored value; a new write is visible the cycle after the edge.

Verification
REQ-029 Reset, IDLE writes r[i]=16'h1000+i for i=0..7, read rd1_addr=3, rd2_addr=7 -> rd1_data=16'h1003, rd2_data=16'h1007.
REQ-030 sv_start pulse, sv_ready=1 -> eight beats sv_idx 0..7 data 16'h1000..16'h1007 on consecutive cycles, ctx_done one cycle after beat 7, busy low thereafter.
REQ-031 SAVE with sv_ready toggled 1,0,0,1,... -> no beat lost or duplicated, sv_idx/sv_data stable during stalls, wr_en=1 wr_addr=2 wr_data=16'hDEAD during SAVE leaves r[2]=16'h1002.
REQ-032 rs_start and sv_start same cycle -> SAVE taken; then rs_start with rs_data 16'hA000+i, rs_valid gapped -> r[i]=16'hA000+i, ctx_done once.
REQ-033 rst_n low after 3 restore beats -> all registers 0, busy=0, no ctx_done; new rs_start restarts at cnt=0.
REQ-034 wr_en=1 wr_addr=5 wr_data=16'h5A5A with rd1_addr=5 -> rd1_data=16'h5A5A same cycle with REG_BANK_BYPASS_EN, old value same cycle and 16'h5A5A next cycle without.
